// File: rtl/nios_system_pio_pkg.sv
// rtl/nios_system_pio_pkg.sv - shared register map and edge-type encoding for the input PIO
//
// Contents:
//   ADDR_DATA, ADDR_IRQMASK, ADDR_EDGECAP : word offsets on the 2-bit slave address
//   edge_type_e                           : encoding of the EDGE_TYPE parameter
package nios_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/nios_system_sync_edge.sv
// rtl/nios_system_sync_edge.sv - in_port synchronizer, previous-sample flop, arm counter, edge select
//
// Ports:
//   clk        in   1      system clock, posedge
//   reset_n    in   1      synchronous active-low reset
//   in_port    in   WIDTH  asynchronous external input
//   sync_q     out  WIDTH  in_port after SYNC_STAGES flops
//   edge_pulse out  WIDTH  one-cycle pulse per bit on the selected edge, gated until armed
module nios_system_sync_edge
    import nios_system_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_pulse
);

    // Detection stays off until the chain and prev flop hold genuine samples,
    // so a level already present at reset release is never seen as an edge.
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W      = $clog2(ARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
    logic [WIDTH-1:0]                  prev_q;
    logic [CNT_W-1:0]                  arm_cnt_q, arm_cnt_d;
    logic                              armed;
    logic [WIDTH-1:0]                  rise, fall, edge_raw;

    assign sync_q = chain_q[SYNC_STAGES-1];
    assign armed  = (arm_cnt_q == CNT_W'(ARM_CYCLES));

    always_comb begin
        chain_d   = {chain_q[SYNC_STAGES-2:0], in_port};
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain_q   <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
        end else begin
            chain_q   <= chain_d;
            prev_q    <= sync_q;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

    always_comb begin
        edge_raw = rise;
        if (EDGE_TYPE == int'(EDGE_FALL)) begin
            edge_raw = fall;
        end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
            edge_raw = rise | fall;
        end
    end

    assign edge_pulse = armed ? edge_raw : '0;

endmodule

// File: rtl/nios_system_data_in.sv
// rtl/nios_system_data_in.sv - Avalon-MM input PIO with edge capture, IRQ mask and level interrupt
//
// Optional feature macro: NIOS_SYSTEM_DATA_IN_BIT_CLEAR_EN
//   defined   : write to EDGECAP clears only bits where writedata[i]=1
//   undefined : any write to EDGECAP clears every captured bit
//
// Ports:
//   clk        in   1      system clock, posedge
//   reset_n    in   1      synchronous active-low reset
//   address    in   2      word offset: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAP
//   chipselect in   1      slave select
//   write_n    in   1      active-low write strobe
//   writedata  in   32     write data, bits [WIDTH-1:0] used
//   in_port    in   WIDTH  asynchronous external input
//   readdata   out  32     registered, zero-extended read data (1-cycle latency)
//   irq        out  1      |(edge_capture & irq_mask)
module nios_system_data_in
    import nios_system_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] clr_bits;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;
    logic             unused_wdata;

    nios_system_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .sync_q     (sync_q),
        .edge_pulse (edge_pulse)
    );

    // Upper writedata bits beyond WIDTH have no destination.
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect && !write_n;

    always_comb begin
        clr_bits = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
`ifdef NIOS_SYSTEM_DATA_IN_BIT_CLEAR_EN
            clr_bits = writedata[WIDTH-1:0];
`else
            clr_bits = '1;
`endif
        end
    end

    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        // OR-ing the new pulses after the clear makes a coincident edge win.
        edge_capture_d = (edge_capture_q & ~clr_bits) | edge_pulse;
    end

    // Read mux runs every cycle; no read strobe exists on this slave.
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_q;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_capture_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
        end else begin
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_nios_system_data_in.sv
// tb/tb_nios_system_data_in.sv - table-driven bench for nios_system_data_in (WIDTH=8, SYNC_STAGES=2, rising edge)
module tb_nios_system_data_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    nios_system_data_in #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .EDGE_TYPE   (0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

`ifdef NIOS_SYSTEM_DATA_IN_BIT_CLEAR_EN
    localparam logic [31:0] CLR4 = 32'h02;
`else
    localparam logic [31:0] CLR4 = 32'h00;
`endif

    typedef struct {
        logic        rst_n;
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [7:0]  inp;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_fail    = 0;

    task automatic add(input logic rst_n, input logic cs, input logic wn, input logic [1:0] addr,
                       input logic [31:0] wd, input logic [7:0] inp, input logic chk_rd,
                       input logic [31:0] exp_rd, input logic exp_irq);
        vec_t v;
        v.rst_n = rst_n; v.cs = cs; v.wn = wn; v.addr = addr; v.wd = wd; v.inp = inp;
        v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst_n, input logic cs, input logic wn, input logic [1:0] addr,
                         input logic [31:0] wd, input logic [7:0] inp);
        reset_n = rst_n; chipselect = cs; write_n = wn; address = addr; writedata = wd; in_port = inp;
    endtask

    initial begin
        int cycles;
        drive(1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 8'hA5);

        // in_port high through reset: no spurious capture, DATA reads back
        add(0,0,1,0,0,8'hA5, 1,32'h00,0);
        add(0,0,1,0,0,8'hA5, 1,32'h00,0);
        add(1,0,1,0,0,8'hA5, 1,32'h00,0);
        add(1,0,1,0,0,8'hA5, 1,32'h00,0);
        add(1,0,1,3,0,8'hA5, 1,32'h00,0);
        add(1,0,1,3,0,8'hA5, 1,32'h00,0);
        add(1,0,1,0,0,8'hA5, 1,32'hA5,0);
        // rising edge on bit0 with mask 01, latency SYNC_STAGES+1
        add(1,0,1,0,0,8'hA4, 1,32'hA5,0);
        add(1,1,0,2,32'h01,8'hA4, 1,32'h00,0);
        add(1,0,1,2,0,8'hA4, 1,32'h01,0);
        add(1,0,1,3,0,8'hA5, 1,32'h00,0);
        add(1,0,1,3,0,8'hA5, 1,32'h00,0);
        add(1,0,1,3,0,8'hA5, 1,32'h00,1);
        add(1,0,1,3,0,8'hA5, 1,32'h01,1);
        add(1,1,0,3,32'hFF,8'hA5, 1,32'h01,0);
        // falling edge is not captured
        add(1,0,1,3,0,8'hA4, 1,32'h00,0);
        for (int i = 0; i < 4; i++) add(1,0,1,3,0,8'hA4, 1,32'h00,0);
        // capture 03, mask 02 then 0
        add(1,0,1,3,0,8'hA7, 1,32'h00,0);
        add(1,0,1,3,0,8'hA7, 1,32'h00,0);
        add(1,0,1,3,0,8'hA7, 1,32'h00,1);
        add(1,1,0,2,32'h02,8'hA7, 1,32'h01,1);
        add(1,0,1,2,0,8'hA7, 1,32'h02,1);
        add(1,1,0,2,32'h00,8'hA7, 1,32'h02,0);
        add(1,0,1,3,0,8'hA7, 1,32'h03,0);
        // clear write of 01 to EDGECAP
        add(1,1,0,3,32'h01,8'hA7, 1,32'h03,0);
        add(1,0,1,3,0,8'hA7, 1,CLR4,0);
        // edge coincident with clear: set wins
        for (int i = 0; i < 4; i++) add(1,0,1,3,0,8'hA6, 1,CLR4,0);
        add(1,1,0,3,32'hFF,8'hA6, 1,CLR4,0);
        add(1,0,1,3,0,8'hA7, 1,32'h00,0);
        add(1,0,1,3,0,8'hA7, 1,32'h00,0);
        add(1,1,0,3,32'hFF,8'hA7, 1,32'h00,0);
        add(1,0,1,3,0,8'hA7, 1,32'h01,0);
        // capture FF, mask FF, then reset mid-run
        for (int i = 0; i < 4; i++) add(1,0,1,3,0,8'h00, 1,32'h01,0);
        add(1,0,1,3,0,8'hFF, 1,32'h01,0);
        add(1,0,1,3,0,8'hFF, 1,32'h01,0);
        add(1,0,1,3,0,8'hFF, 1,32'h01,0);
        add(1,1,0,2,32'hFF,8'hFF, 1,32'h00,1);
        add(1,0,1,3,0,8'hFF, 1,32'hFF,1);
        add(0,0,1,3,0,8'hFF, 1,32'h00,0);
        add(1,1,0,0,32'hFF,8'hFF, 1,32'h00,0);
        add(1,1,0,1,32'hFF,8'hFF, 1,32'h00,0);
        add(1,0,1,2,0,8'hFF, 1,32'h00,0);
        add(1,0,1,3,0,8'hFF, 1,32'h00,0);
        add(1,0,1,3,0,8'hFF, 1,32'h00,0);
        add(1,0,1,0,0,8'hFF, 1,32'hFF,0);
        add(1,0,1,1,0,8'hFF, 1,32'h00,0);
        // write strobe without chipselect, chipselect without write strobe
        add(1,0,0,2,32'hFF,8'hFF, 1,32'h00,0);
        add(1,0,1,2,0,8'hFF, 1,32'h00,0);
        add(1,1,1,2,32'hFF,8'hFF, 1,32'h00,0);
        add(1,0,1,2,0,8'hFF, 1,32'h00,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd, vecs[i].inp);
            @(negedge clk);
            if (vecs[i].chk_rd) begin
                n_applied++;
                if (readdata !== vecs[i].exp_rd) begin
                    n_fail++;
                    $display("FAIL vec%0d readdata: got %h expected %h", i, readdata, vecs[i].exp_rd);
                end
            end
            n_applied++;
            if (irq !== vecs[i].exp_irq) begin
                n_fail++;
                $display("FAIL vec%0d irq: got %b expected %b", i, irq, vecs[i].exp_irq);
            end
        end

        // Hand sequence: measure in_port-to-irq latency on bit7
        drive(1, 0, 1, 2'd3, 0, 8'h00);
        repeat (4) @(negedge clk);
        drive(1, 1, 0, 2'd2, 32'h80, 8'h00);
        @(negedge clk);
        drive(1, 0, 1, 2'd3, 0, 8'h80);
        cycles = 0;
        while (cycles < 10) begin
            @(negedge clk);
            cycles++;
            if (irq === 1'b1) break;
        end
        n_applied++;
        if (cycles != 3) begin
            n_fail++;
            $display("FAIL latency_bit7: got %0d cycles expected 3", cycles);
        end
        @(negedge clk);
        n_applied++;
        if (readdata !== 32'h80) begin
            n_fail++;
            $display("FAIL latency_cap: got %h expected %h", readdata, 32'h80);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

endmodule
